mod_counter_load: RTL

Parametrised up/down modulo counter with clear, load, wrap/saturate mode and a wrap-phase bit. It serves as the read/write pointer generator for queues whose depth is not a power of two. Two instances plus a phase compare yield full/empty without a spare address bit. Registered overflow/underflow pulses feed error and status logic.

---
 rtl/cnt_pkg.sv | 15 +
 rtl/mod_counter_load_chk.sv | 25 ++
 rtl/mod_counter_load.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo pointer counter.
//   cnt_mode_e    : boundary behaviour (wrap around or saturate)
//   CNT_PRIORITY  : per-cycle request priority, highest first
package cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Requests are resolved in this order each cycle; lower-priority
    // requests raised in the same cycle are dropped.
    localparam string CNT_PRIORITY = "rst > clr > ld > enb";

endpackage

// File: rtl/mod_counter_load_chk.sv
// Property checker for mod_counter_load, instantiated alongside the counter.
// Ports:
//   clk, rst  : clock and synchronous reset of the checked counter
//   count     : counter value, must stay within 0..MAX
//   ovf, udf  : boundary pulses, mutually exclusive
module mod_counter_load_chk #(
    parameter int DW  = 4,
    parameter int MAX = 2**DW - 1
) (
    input logic          clk,
    input logic          rst,
    input logic [DW-1:0] count,
    input logic          ovf,
    input logic          udf
);

    localparam logic [DW:0] MAX_EXT = (DW+1)'(MAX);

    a_count_in_range: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, count} <= MAX_EXT));

    a_ovf_udf_excl: assert property (@(posedge clk) disable iff (rst)
        !(ovf && udf));

endmodule

// File: rtl/mod_counter_load.sv
// Up/down modulo counter (range 0..MAX) with clear, load, wrap/saturate
// mode and a wrap-phase bit. Used as a read/write pointer generator for
// queues of non-power-of-two depth: two instances plus a phase compare
// give full/empty without a spare address bit.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   enb, up, mode     : step request, direction, boundary behaviour
//   clr, ld, ld_val   : synchronous clear / load (load clamps to MAX)
//   count, phase      : registered count and wrap-phase bit
//   at_max, at_zero   : combinational boundary flags of count
//   ovf, udf          : registered one-cycle boundary-request pulses
module mod_counter_load
    import cnt_pkg::*;
#(
    parameter int DW  = 4,
    parameter int MAX = 2**DW - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          up,
    input  cnt_mode_e     mode,
    input  logic          clr,
    input  logic          ld,
    input  logic [DW-1:0] ld_val,
    output logic [DW-1:0] count,
    output logic          phase,
    output logic          at_max,
    output logic          at_zero,
    output logic          ovf,
    output logic          udf
);

    // Boundary constants carried one bit wider so MAX = 2**DW-1 never
    // aliases with the step result.
    localparam logic [DW:0]   MAX_EXT  = (DW+1)'(MAX);
    localparam logic [DW-1:0] MAX_CNT  = DW'(MAX);
    localparam logic [DW:0]   ONE_EXT  = (DW+1)'(1);
    localparam logic [DW:0]   ZERO_EXT = (DW+1)'(0);

    logic [DW-1:0] count_r;
    logic          phase_r;
    logic          ovf_r;
    logic          udf_r;

    logic [DW-1:0] count_nxt_s;
    logic          phase_nxt_s;
    logic          ovf_nxt_s;
    logic          udf_nxt_s;
    logic [DW:0]   count_ext_s;
    logic [DW:0]   ld_ext_s;

    assign count_ext_s = {1'b0, count_r};
    assign ld_ext_s    = {1'b0, ld_val};

    // Next-state resolution in priority order clr > ld > enb (rst in the flop stage).
    always_comb begin
        count_nxt_s = count_r;
        phase_nxt_s = phase_r;
        ovf_nxt_s   = 1'b0;
        udf_nxt_s   = 1'b0;
        if (clr) begin
            count_nxt_s = '0;
            phase_nxt_s = 1'b0;
        end else if (ld) begin
            // Out-of-range load values clamp silently to MAX.
            if (ld_ext_s > MAX_EXT) begin
                count_nxt_s = MAX_CNT;
            end else begin
                count_nxt_s = ld_val;
            end
            phase_nxt_s = 1'b0;
        end else if (enb) begin
            if (up) begin
                if (count_ext_s == MAX_EXT) begin
                    ovf_nxt_s = 1'b1;
                    if (mode == CNT_WRAP) begin
                        count_nxt_s = '0;
                        phase_nxt_s = ~phase_r;
                    end else begin
                        count_nxt_s = count_r;
                        phase_nxt_s = phase_r;
                    end
                end else begin
                    count_nxt_s = DW'(count_ext_s + ONE_EXT);
                end
            end else begin
                if (count_ext_s == ZERO_EXT) begin
                    udf_nxt_s = 1'b1;
                    if (mode == CNT_WRAP) begin
                        count_nxt_s = MAX_CNT;
                        phase_nxt_s = ~phase_r;
                    end else begin
                        count_nxt_s = count_r;
                        phase_nxt_s = phase_r;
                    end
                end else begin
                    count_nxt_s = DW'(count_ext_s - ONE_EXT);
                end
            end
        end else begin
            count_nxt_s = count_r;
            phase_nxt_s = phase_r;
        end
    end

    // State and pulse registers; reset overrides every request on its edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            phase_r <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            phase_r <= phase_nxt_s;
            ovf_r   <= ovf_nxt_s;
            udf_r   <= udf_nxt_s;
        end
    end

    assign count   = count_r;
    assign phase   = phase_r;
    assign ovf     = ovf_r;
    assign udf     = udf_r;
    assign at_max  = (count_r == MAX_CNT);
    assign at_zero = (count_r == '0);

endmodule
